// File: rtl/ram_wait.sv
// ram_wait: byte-addressable data RAM for the MSP430 data bus.
// Adds a req/rdy handshake with programmable wait states and an
// out-of-range error flag. It can also zero the whole array after reset.
// Bytes are kept in two banks (even/odd lane). A word access and a
// byte access each need only one write port per bank.
module ram_wait #(
   parameter logic [15:0] BOUND_L        = 16'h0200,
   parameter logic [15:0] BOUND_U        = 16'h0400,
   parameter int          WAIT_STATES    = 0,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter              INIT_FILE      = ""
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ram_req,
   input  logic [15:0] ram_addr,
   input  logic [15:0] ram_Din,
   input  logic        ram_RW,
   input  logic        BW,
   output logic [15:0] ram_out,
   output logic        ram_rdy,
   output logic        ram_err,
   output logic        ram_busy
);

   localparam int SIZE = int'(BOUND_U) - int'(BOUND_L);
   localparam int AW   = $clog2(SIZE);
   localparam int HALF = SIZE / 2;
   localparam logic [AW-1:0] LAST_PTR = AW'(SIZE - 1);

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_IDLE  = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Preloading from INIT_FILE is a simulation-time action done on the
   // r_mem_lo / r_mem_hi arrays by the surrounding environment.
   if (INIT_FILE != "") begin : g_init_hook
   end

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic [AW-1:0] r_ptr;
   logic [15:0]   r_addr;
   logic [15:0]   r_din;
   logic          r_rw;
   logic          r_bw;
   logic [15:0]   r_out;
   logic          r_rdy;
   logic          r_err;
   logic          r_busy;

   logic [7:0]    r_mem_lo [HALF];
   logic [7:0]    r_mem_hi [HALF];

   logic [AW-1:0] w_off;
   logic [AW-2:0] w_idx;
   logic          w_lane;
   logic          w_in_range;
   logic          w_access;
   logic [7:0]    w_rd_lo;
   logic [7:0]    w_rd_hi;
   logic [15:0]   w_rd_data;
   logic          w_lo_we;
   logic          w_hi_we;
   logic [7:0]    w_lo_wdata;
   logic [7:0]    w_hi_wdata;
   logic [AW-2:0] w_wr_idx;

   assign w_off      = AW'(r_addr - BOUND_L);
   assign w_idx      = w_off[AW-1:1];
   assign w_lane     = w_off[0];
   assign w_in_range = (r_addr >= BOUND_L) && (r_addr < BOUND_U);
   assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);
   assign w_rd_lo    = r_mem_lo[w_idx];
   assign w_rd_hi    = r_mem_hi[w_idx];

   // Read data: out-of-range reads return zero; byte reads zero-extend the lane
   always_comb begin
      w_rd_data = 16'h0000;
      if (w_in_range) begin
         if (r_bw) begin
            w_rd_data = {8'h00, (w_lane ? w_rd_hi : w_rd_lo)};
         end else begin
            w_rd_data = {w_rd_hi, w_rd_lo};
         end
      end
   end

   // Bank write enables: clear sweep first, then a completing in-range write.
   // Both depend on r_state, so an async reset drops them at once and
   // discards any pending write.
   always_comb begin
      w_lo_we    = 1'b0;
      w_hi_we    = 1'b0;
      w_lo_wdata = 8'h00;
      w_hi_wdata = 8'h00;
      w_wr_idx   = w_idx;
      if (r_state == S_CLEAR) begin
         w_wr_idx = r_ptr[AW-1:1];
         w_lo_we  = ~r_ptr[0];
         w_hi_we  = r_ptr[0];
      end else if (w_access && r_rw && w_in_range) begin
         if (r_bw) begin
            w_lo_we    = ~w_lane;
            w_hi_we    = w_lane;
            w_lo_wdata = r_din[7:0];
            w_hi_wdata = r_din[7:0];
         end else begin
            w_lo_we    = 1'b1;
            w_hi_we    = 1'b1;
            w_lo_wdata = r_din[7:0];
            w_hi_wdata = r_din[15:8];
         end
      end
   end

   // Byte-lane memory banks: plain synchronous writes, no reset on contents
   always_ff @(posedge clk) begin
      if (w_lo_we) r_mem_lo[w_wr_idx] <= w_lo_wdata;
      if (w_hi_we) r_mem_hi[w_wr_idx] <= w_hi_wdata;
   end

   // Control FSM: clear sweep, request capture, wait countdown, completion pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
         r_busy  <= CLEAR_ON_RESET;
         r_cnt   <= 4'd0;
         r_ptr   <= '0;
         r_addr  <= 16'h0000;
         r_din   <= 16'h0000;
         r_rw    <= 1'b0;
         r_bw    <= 1'b0;
         r_out   <= 16'h0000;
         r_rdy   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               if (r_ptr == LAST_PTR) begin
                  r_ptr   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end
            S_IDLE: begin
               if (ram_req) begin
                  r_addr  <= ram_addr;
                  r_din   <= ram_Din;
                  r_rw    <= ram_RW;
                  r_bw    <= BW;
                  r_cnt   <= 4'(WAIT_STATES);
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_rdy   <= 1'b1;
                  r_err   <= ~w_in_range;
                  if (!r_rw) r_out <= w_rd_data;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_rdy   <= 1'b0;
               r_err   <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ram_out  = r_out;
   assign ram_rdy  = r_rdy;
   assign ram_err  = r_err;
   assign ram_busy = r_busy;

endmodule

// File: tb/tb_ram_wait.sv
// tb_ram_wait: directed, table-driven bench for ram_wait.
// u_dut0 uses zero wait states and clears the array after reset.
// u_dut1 uses three wait states and keeps its contents over reset.
`timescale 1ns/1ps
module tb_ram_wait;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [2];
   logic        req   [2];
   logic [15:0] addr  [2];
   logic [15:0] din   [2];
   logic        rw    [2];
   logic        bw    [2];
   logic [15:0] dout  [2];
   logic        rdy   [2];
   logic        err   [2];
   logic        busy  [2];

   ram_wait #(.WAIT_STATES(0), .CLEAR_ON_RESET(1'b1)) u_dut0 (
      .clk(clk), .rst_n(rst_n[0]), .ram_req(req[0]), .ram_addr(addr[0]),
      .ram_Din(din[0]), .ram_RW(rw[0]), .BW(bw[0]), .ram_out(dout[0]),
      .ram_rdy(rdy[0]), .ram_err(err[0]), .ram_busy(busy[0]));

   ram_wait #(.WAIT_STATES(3), .CLEAR_ON_RESET(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n[1]), .ram_req(req[1]), .ram_addr(addr[1]),
      .ram_Din(din[1]), .ram_RW(rw[1]), .BW(bw[1]), .ram_out(dout[1]),
      .ram_rdy(rdy[1]), .ram_err(err[1]), .ram_busy(busy[1]));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rw;
      logic        bw;
      logic [15:0] addr;
      logic [15:0] din;
      logic [15:0] exp_out;
      logic        exp_err;
   } vec_t;

   vec_t       vecs  [19];
   logic [7:0] model [512];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_write(input logic [15:0] a, input logic [15:0] d, input logic b);
      int off;
      if (a >= 16'h0200 && a < 16'h0400) begin
         off = int'(a) - 16'h0200;
         if (b) begin
            model[off] = d[7:0];
         end else begin
            off = off & ~1;
            model[off]     = d[7:0];
            model[off + 1] = d[15:8];
         end
      end
   endtask

   // One complete transaction on DUT d; inputs are scrambled after capture.
   task automatic access(input int d, input logic w, input logic b,
                         input logic [15:0] a, input logic [15:0] dn,
                         input bit verbose,
                         output logic [15:0] o, output logic e, output int lat);
      req[d] = 1'b1; rw[d] = w; bw[d] = b; addr[d] = a; din[d] = dn;
      @(posedge clk); #1;
      req[d]  = 1'b0;
      addr[d] = 16'($urandom);
      din[d]  = 16'($urandom);
      rw[d]   = 1'($urandom);
      bw[d]   = 1'($urandom);
      lat = 0; o = 16'h0000; e = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (rdy[d]) begin
            lat = i; o = dout[d]; e = err[d];
            break;
         end
      end
      @(posedge clk); #1;
      check("rdy_pulse_width", {15'b0, rdy[d]}, 16'h0000);
      check("err_after_done", {15'b0, err[d]}, 16'h0000);
      if (verbose)
         $display("dut%0d %s %s addr=%h din=%h -> out=%h err=%b latency=%0d",
                  d, w ? "WR" : "RD", b ? "byte" : "word", a, dn, o, e, lat);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] o;
      logic        e;
      int          lat;
      int          n;
      bit          seen;

      vecs[0]  = '{1'b0, 1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 16'h0200, 16'hBEEF, 16'h0000, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 16'h0201, 16'h0000, 16'h00BE, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 16'h0200, 16'h0000, 16'h00EF, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 16'h0203, 16'h1234, 16'h00EF, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 16'h0202, 16'h0000, 16'h3400, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 16'h0205, 16'hA55A, 16'h3400, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 16'h0204, 16'h0000, 16'hA55A, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 16'h01FE, 16'hFFFF, 16'hA55A, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 16'h0400, 16'h0000, 16'h0000, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 16'h0206, 16'h0000, 16'h0000, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 16'h03FE, 16'h0000, 16'h0000, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 16'h03FE, 16'h1357, 16'h0000, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 16'h03FE, 16'h0000, 16'h1357, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1'b1};
      vecs[16] = '{1'b0, 1'b1, 16'h03FF, 16'h0000, 16'h0013, 1'b0};
      vecs[17] = '{1'b1, 1'b1, 16'h0200, 16'h00AA, 16'h0013, 1'b0};
      vecs[18] = '{1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEAA, 1'b0};
      for (int i = 0; i < 512; i++) model[i] = 8'h00;

      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; req[d] = 1'b0; addr[d] = 16'h0000;
         din[d] = 16'h0000; rw[d] = 1'b0; bw[d] = 1'b0;
      end

      // Reset values while rst_n is held low
      repeat (3) @(posedge clk);
      #1;
      check("reset_out0",  dout[0], 16'h0000);
      check("reset_rdy0",  {15'b0, rdy[0]},  16'h0000);
      check("reset_err0",  {15'b0, err[0]},  16'h0000);
      check("reset_busy0", {15'b0, busy[0]}, 16'h0001);
      check("reset_out1",  dout[1], 16'h0000);
      check("reset_busy1", {15'b0, busy[1]}, 16'h0000);
      $display("reset: busy0=%b busy1=%b out0=%h out1=%h", busy[0], busy[1], dout[0], dout[1]);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      // Reset in the middle of the sweep restarts it
      repeat (100) @(posedge clk);
      #1;
      check("busy_mid_sweep", {15'b0, busy[0]}, 16'h0001);
      rst_n[0] = 1'b0;
      @(posedge clk); #1;
      rst_n[0] = 1'b1;

      // Sweep length with a request held high throughout: not accepted early
      req[0] = 1'b1; rw[0] = 1'b0; bw[0] = 1'b0; addr[0] = 16'h0200;
      n = 0; seen = 1'b0;
      for (int i = 0; i < 700; i++) begin
         @(posedge clk); #1;
         n++;
         if (rdy[0]) seen = 1'b1;
         if (!busy[0]) break;
      end
      check("busy_cycles", 16'(n), 16'd512);
      check("no_rdy_during_clear", {15'b0, seen}, 16'h0000);
      $display("clear sweep: busy cycles=%0d", n);
      @(posedge clk); #1;
      req[0] = 1'b0;
      @(posedge clk); #1;
      check("held_req_rdy", {15'b0, rdy[0]}, 16'h0001);
      check("held_req_out", dout[0], 16'h0000);
      check("held_req_err", {15'b0, err[0]}, 16'h0000);
      $display("dut0 RD word addr=0200 (held through clear) -> out=%h err=%b", dout[0], err[0]);
      @(posedge clk); #1;

      // Table of single transactions on the zero-wait-state instance
      for (int i = 0; i < 19; i++) begin
         access(0, vecs[i].rw, vecs[i].bw, vecs[i].addr, vecs[i].din, 1'b1, o, e, lat);
         check($sformatf("vec%0d_out", i), o, vecs[i].exp_out);
         check($sformatf("vec%0d_err", i), {15'b0, e}, {15'b0, vecs[i].exp_err});
         check($sformatf("vec%0d_latency", i), 16'(lat), 16'd1);
         if (vecs[i].rw) model_write(vecs[i].addr, vecs[i].din, vecs[i].bw);
      end

      // Full dump of the mapped range against the byte model
      for (int a = 16'h0200; a < 16'h0400; a += 2) begin
         access(0, 1'b0, 1'b0, 16'(a), 16'h0000, 1'b0, o, e, lat);
         check($sformatf("dump_%h", 16'(a)), o, {model[a - 16'h0200 + 1], model[a - 16'h0200]});
      end
      $display("dump of 0200..03FF compared against model");

      // Three wait states, contents kept over reset
      check("busy1_idle", {15'b0, busy[1]}, 16'h0000);
      access(1, 1'b1, 1'b0, 16'h0210, 16'h2222, 1'b1, o, e, lat);
      check("ws3_write_latency", 16'(lat), 16'd4);
      access(1, 1'b0, 1'b0, 16'h0210, 16'h0000, 1'b1, o, e, lat);
      check("ws3_read_latency", 16'(lat), 16'd4);
      check("ws3_read_out", o, 16'h2222);

      // Abort a write with reset during the wait countdown
      req[1] = 1'b1; rw[1] = 1'b1; bw[1] = 1'b0; addr[1] = 16'h0210; din[1] = 16'h1111;
      @(posedge clk); #1;
      req[1] = 1'b0;
      seen = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (rdy[1]) seen = 1'b1;
      end
      rst_n[1] = 1'b0;
      #1;
      check("abort_busy", {15'b0, busy[1]}, 16'h0000);
      repeat (2) begin
         @(posedge clk); #1;
         if (rdy[1]) seen = 1'b1;
      end
      rst_n[1] = 1'b1;
      repeat (8) begin
         @(posedge clk); #1;
         if (rdy[1]) seen = 1'b1;
      end
      check("abort_no_rdy", {15'b0, seen}, 16'h0000);
      $display("dut1 WR word addr=0210 din=1111 aborted by reset, rdy seen=%b", seen);
      access(1, 1'b0, 1'b0, 16'h0210, 16'h0000, 1'b1, o, e, lat);
      check("abort_kept_value", o, 16'h2222);
      check("abort_read_err", {15'b0, e}, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
